sysid_check_sequencer: RTL and testbench

- Sequences reads of the system-ID peripheral (1-bit address, 32-bit readdata; address 0 = ID word, address 1 = build timestamp) and compares both words against build-time expected values.
- Runs once automatically after reset and again on each start pulse.
- Publishes registered match/status flags to boot logic and to a status register visible to software.
- Sits between reset/boot control and the sysid slave as the slave's only master.

---
 rtl/sysid_check_sequencer_pkg.sv | 21 ++
 rtl/sysid_check_sequencer_if.sv | 20 ++
 rtl/sysid_check_sequencer.sv | 146 ++++++++++++++
 tb/tb_sysid_check_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_sequencer_pkg.sv
// Shared types and constants for the system-ID check sequencer.
// Holds the FSM state encoding, the sysid word addresses and the counter widths.
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP,
    DONE
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int LAT_CNT_W   = 3;
  localparam int CHECK_CNT_W = 8;

  localparam logic [CHECK_CNT_W-1:0] CHECK_CNT_MAX = '1;

endpackage

// File: rtl/sysid_check_sequencer_if.sv
// Read-only bus between the check sequencer (master) and the sysid peripheral (slave).
interface sysid_check_sequencer_if;

  logic        sysid_address;
  logic        sysid_read;
  logic [31:0] sysid_readdata;

  modport master (
    output sysid_address,
    output sysid_read,
    input  sysid_readdata
  );

  modport slave (
    input  sysid_address,
    input  sysid_read,
    output sysid_readdata
  );

endinterface

// File: rtl/sysid_check_sequencer.sv
// Reads the sysid ID and timestamp words and compares them with build-time constants.
// Runs once after reset (when AUTO_START is set) and again on every start request seen in IDLE.
module sysid_check_sequencer
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1486161713,
  parameter int          READ_LATENCY = 1,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  sysid_check_sequencer_if.master sysid,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    match,
  output logic [31:0]             id_value,
  output logic [31:0]             ts_value,
  output logic [CHECK_CNT_W-1:0]  check_count
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LATENCY);

  state_t                 state_reg, state_next;
  logic [LAT_CNT_W-1:0]   lat_cnt_reg, lat_cnt_next;
  logic                   auto_arm_reg, auto_arm_next;
  logic                   read_reg, read_next;
  logic                   addr_reg, addr_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   id_ok_reg, id_ok_next;
  logic                   ts_ok_reg, ts_ok_next;
  logic                   match_reg, match_next;
  logic [31:0]            id_value_reg, id_value_next;
  logic [31:0]            ts_value_reg, ts_value_next;
  logic [CHECK_CNT_W-1:0] check_count_reg, check_count_next;

  always_comb begin
    state_next       = state_reg;
    lat_cnt_next     = lat_cnt_reg;
    auto_arm_next    = auto_arm_reg;
    id_ok_next       = id_ok_reg;
    ts_ok_next       = ts_ok_reg;
    match_next       = match_reg;
    id_value_next    = id_value_reg;
    ts_value_next    = ts_value_reg;
    check_count_next = check_count_reg;

    case (state_reg)
      IDLE: begin
        if (start || auto_arm_reg) begin
          auto_arm_next = 1'b0;
          id_ok_next    = 1'b0;
          ts_ok_next    = 1'b0;
          match_next    = 1'b0;
          lat_cnt_next  = '0;
          state_next    = RD_ID;
        end
      end
      RD_ID: begin
        if (lat_cnt_reg == LAT_LAST) begin
          id_value_next = sysid.sysid_readdata;
          lat_cnt_next  = '0;
          state_next    = RD_TS;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_CNT_W'(1);
        end
      end
      RD_TS: begin
        if (lat_cnt_reg == LAT_LAST) begin
          ts_value_next = sysid.sysid_readdata;
          lat_cnt_next  = '0;
          state_next    = CMP;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_CNT_W'(1);
        end
      end
      CMP: begin
        id_ok_next = (id_value_reg == EXPECTED_ID);
        ts_ok_next = (ts_value_reg == EXPECTED_TS);
        match_next = (id_value_reg == EXPECTED_ID) && (ts_value_reg == EXPECTED_TS);
        state_next = DONE;
      end
      DONE: begin
        if (check_count_reg != CHECK_CNT_MAX) begin
          check_count_next = check_count_reg + CHECK_CNT_W'(1);
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Bus and status strobes are decoded from the upcoming state so they are registered yet state-aligned.
    read_next = (state_next == RD_ID) || (state_next == RD_TS);
    addr_next = (state_next == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      lat_cnt_reg     <= '0;
      auto_arm_reg    <= AUTO_START;
      read_reg        <= 1'b0;
      addr_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      id_ok_reg       <= 1'b0;
      ts_ok_reg       <= 1'b0;
      match_reg       <= 1'b0;
      id_value_reg    <= '0;
      ts_value_reg    <= '0;
      check_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      lat_cnt_reg     <= lat_cnt_next;
      auto_arm_reg    <= auto_arm_next;
      read_reg        <= read_next;
      addr_reg        <= addr_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      id_ok_reg       <= id_ok_next;
      ts_ok_reg       <= ts_ok_next;
      match_reg       <= match_next;
      id_value_reg    <= id_value_next;
      ts_value_reg    <= ts_value_next;
      check_count_reg <= check_count_next;
    end
  end

  assign sysid.sysid_read    = read_reg;
  assign sysid.sysid_address = addr_reg;
  assign busy                = busy_reg;
  assign done                = done_reg;
  assign id_ok               = id_ok_reg;
  assign ts_ok               = ts_ok_reg;
  assign match               = match_reg;
  assign id_value            = id_value_reg;
  assign ts_value            = ts_value_reg;
  assign check_count         = check_count_reg;

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// Bench for the sysid check sequencer: one instance with auto-start and latency 1, one without
// auto-start and latency 3, each reading from a simple behavioural sysid slave.
module tb_sysid_check_sequencer;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1486161713;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_r;
  logic [1:0]  start_r;
  logic [31:0] id_word [2];
  logic [31:0] ts_word [2];

  logic [1:0]  busy_w, done_w, idok_w, tsok_w, match_w, read_w, addr_w;
  logic [31:0] idv_w [2];
  logic [31:0] tsv_w [2];
  logic [7:0]  cnt_w [2];

  int total = 0;
  int bad   = 0;
  int model_cnt [2];

  sysid_check_sequencer_if bus_a ();
  sysid_check_sequencer_if bus_b ();

  // Slave model: the addressed word is presented continuously.
  assign bus_a.sysid_readdata = bus_a.sysid_address ? ts_word[0] : id_word[0];
  assign bus_b.sysid_readdata = bus_b.sysid_address ? ts_word[1] : id_word[1];
  assign read_w = {bus_b.sysid_read, bus_a.sysid_read};
  assign addr_w = {bus_b.sysid_address, bus_a.sysid_address};

  sysid_check_sequencer #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(1), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clk), .reset(rst_r[0]), .start(start_r[0]), .sysid(bus_a),
    .busy(busy_w[0]), .done(done_w[0]), .id_ok(idok_w[0]), .ts_ok(tsok_w[0]),
    .match(match_w[0]), .id_value(idv_w[0]), .ts_value(tsv_w[0]), .check_count(cnt_w[0])
  );

  sysid_check_sequencer #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(3), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clk), .reset(rst_r[1]), .start(start_r[1]), .sysid(bus_b),
    .busy(busy_w[1]), .done(done_w[1]), .id_ok(idok_w[1]), .ts_ok(tsok_w[1]),
    .match(match_w[1]), .id_value(idv_w[1]), .ts_value(tsv_w[1]), .check_count(cnt_w[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // One complete check: start is requested (or auto-start/reset release happened) at the current negedge.
  task automatic run_check(input int d, input logic [31:0] idw, input logic [31:0] tsw,
                           input bit pulse, input bit extra);
    int lat, want_lat, got, n_rd0, n_rd1, flag_bad, next_cnt;
    lat      = lat_of(d);
    want_lat = 2 * (lat + 1) + 2;
    got      = -1;
    n_rd0    = 0;
    n_rd1    = 0;
    flag_bad = 0;
    next_cnt = (model_cnt[d] < 255) ? model_cnt[d] + 1 : 255;
    id_word[d] = idw;
    ts_word[d] = tsw;
    if (pulse) start_r[d] = 1'b1;
    for (int j = 1; j <= 40 && got < 0; j++) begin
      @(negedge clk);
      start_r[d] = extra && (j == lat + 2 || j == 2 * lat + 3);
      if (read_w[d]) begin
        if (addr_w[d]) n_rd1++;
        else n_rd0++;
      end
      if (done_w[d]) got = j;
      else if (idok_w[d] || tsok_w[d] || match_w[d]) flag_bad++;
    end
    total++; if (got !== want_lat) begin bad++; $display("FAIL done_latency d%0d: got %0d want %0d", d, got, want_lat); end
    total++; if (n_rd0 !== lat + 1) begin bad++; $display("FAIL reads_addr0 d%0d: got %0d want %0d", d, n_rd0, lat + 1); end
    total++; if (n_rd1 !== lat + 1) begin bad++; $display("FAIL reads_addr1 d%0d: got %0d want %0d", d, n_rd1, lat + 1); end
    total++; if (flag_bad !== 0) begin bad++; $display("FAIL flags_while_busy d%0d: got %0d cycles set want 0", d, flag_bad); end
    total++; if (idok_w[d] !== (idw == EXP_ID)) begin bad++; $display("FAIL id_ok d%0d: got %b want %b", d, idok_w[d], idw == EXP_ID); end
    total++; if (tsok_w[d] !== (tsw == EXP_TS)) begin bad++; $display("FAIL ts_ok d%0d: got %b want %b", d, tsok_w[d], tsw == EXP_TS); end
    total++; if (match_w[d] !== (idw == EXP_ID && tsw == EXP_TS)) begin bad++; $display("FAIL match d%0d: got %b want %b", d, match_w[d], idw == EXP_ID && tsw == EXP_TS); end
    total++; if (idv_w[d] !== idw) begin bad++; $display("FAIL id_value d%0d: got %h want %h", d, idv_w[d], idw); end
    total++; if (tsv_w[d] !== tsw) begin bad++; $display("FAIL ts_value d%0d: got %h want %h", d, tsv_w[d], tsw); end
    @(negedge clk);
    start_r[d] = 1'b0;
    total++; if ({done_w[d], busy_w[d]} !== 2'b00) begin bad++; $display("FAIL after_done d%0d: got done,busy=%b want 00", d, {done_w[d], busy_w[d]}); end
    total++; if (cnt_w[d] !== 8'(next_cnt)) begin bad++; $display("FAIL check_count d%0d: got %0d want %0d", d, cnt_w[d], next_cnt); end
    model_cnt[d] = next_cnt;
    $display("check d%0d id=%h ts=%h latency=%0d count=%0d", d, idw, tsw, got, cnt_w[d]);
  endtask

  task automatic test_reset();
    rst_r      = 2'b11;
    start_r    = 2'b00;
    id_word[0] = EXP_ID; ts_word[0] = EXP_TS;
    id_word[1] = EXP_ID; ts_word[1] = EXP_TS;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy_w[d], done_w[d], idok_w[d], tsok_w[d], match_w[d], read_w[d], addr_w[d],
           idv_w[d], tsv_w[d], cnt_w[d]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs d%0d: got busy=%b read=%b id=%h ts=%h cnt=%0d want all 0",
                 d, busy_w[d], read_w[d], idv_w[d], tsv_w[d], cnt_w[d]);
      end
    end
    $display("reset checked");
  endtask

  task automatic test_auto_start();
    rst_r = 2'b00;
    run_check(0, EXP_ID, EXP_TS, 1'b0, 1'b0);
  endtask

  task automatic test_no_auto_start();
    int act;
    act = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy_w[1] || read_w[1]) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL no_auto_activity: got %0d busy cycles want 0", act); end
    total++; if (cnt_w[1] !== 8'd0) begin bad++; $display("FAIL no_auto_count: got %0d want 0", cnt_w[1]); end
    $display("no auto-start idle cycles=%0d", act);
  endtask

  task automatic test_ts_mismatch();
    run_check(0, EXP_ID, 32'hDEADBEEF, 1'b1, 1'b0);
  endtask

  task automatic test_long_latency();
    run_check(1, EXP_ID, EXP_TS, 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int act;
    run_check(1, $urandom(), EXP_TS, 1'b1, 1'b1);
    act = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy_w[1] || done_w[1]) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL busy_start_ignored: got %0d busy cycles want 0", act); end
    total++; if (cnt_w[1] !== 8'(model_cnt[1])) begin bad++; $display("FAIL busy_start_count: got %0d want %0d", cnt_w[1], model_cnt[1]); end
    $display("start while busy: extra activity cycles=%0d", act);
  endtask

  task automatic test_reset_mid();
    id_word[0] = EXP_ID;
    ts_word[0] = EXP_TS;
    start_r[0] = 1'b1;
    for (int j = 1; j <= lat_of(0) + 2; j++) begin
      @(negedge clk);
      start_r[0] = 1'b0;
    end
    total++; if ({read_w[0], addr_w[0]} !== 2'b11) begin bad++; $display("FAIL mid_in_rd_ts: got read,addr=%b want 11", {read_w[0], addr_w[0]}); end
    rst_r[0] = 1'b1;
    #1;
    total++;
    if ({busy_w[0], done_w[0], idok_w[0], tsok_w[0], match_w[0], read_w[0], addr_w[0],
         idv_w[0], tsv_w[0], cnt_w[0]} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got busy=%b read=%b id=%h ts=%h cnt=%0d want all 0",
               busy_w[0], read_w[0], idv_w[0], tsv_w[0], cnt_w[0]);
    end
    model_cnt[0] = 0;
    @(negedge clk);
    rst_r[0] = 1'b0;
    run_check(0, EXP_ID, EXP_TS, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] idw, tsw;
    for (int i = 0; i < 12; i++) begin
      idw = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
      tsw = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
      run_check(i % 2, idw, tsw, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int n, last, gap_bad, cnt_bad, base, want, period;
    n       = 0;
    last    = -1;
    gap_bad = 0;
    cnt_bad = 0;
    base    = model_cnt[0];
    period  = 2 * (lat_of(0) + 1) + 3;
    start_r[0] = 1'b1;
    for (int cyc = 1; cyc <= 300 * period + 50 && n < 300; cyc++) begin
      @(negedge clk);
      if (done_w[0]) begin
        n++;
        if (last >= 0 && cyc - last != period) gap_bad++;
        last = cyc;
        want = (base + n - 1 > 255) ? 255 : base + n - 1;
        if (cnt_w[0] !== 8'(want)) cnt_bad++;
        if (n == 300) start_r[0] = 1'b0;
      end
    end
    start_r[0] = 1'b0;
    @(negedge clk);
    total++; if (n !== 300) begin bad++; $display("FAIL b2b_done_pulses: got %0d want 300", n); end
    total++; if (gap_bad !== 0) begin bad++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad); end
    total++; if (cnt_bad !== 0) begin bad++; $display("FAIL b2b_count_track: got %0d bad counts want 0", cnt_bad); end
    total++; if (cnt_w[0] !== 8'd255) begin bad++; $display("FAIL b2b_saturate: got %0d want 255", cnt_w[0]); end
    model_cnt[0] = 255;
    $display("back-to-back checks=%0d final count=%0d", n, cnt_w[0]);
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_no_auto_start();
    test_ts_mismatch();
    test_long_latency();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_ts_mismatch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
